// File: rtl/timekeeper_pkg.sv
// timekeeper_pkg: state encodings and BCD limits shared by the clock datapath.
package timekeeper_pkg;
  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10
  } state_e;
  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;
endpackage

// File: rtl/timekeeper_bcd60_inc.sv
// bcd60_inc: two-digit BCD increment, wrapping to 00 with carry after limit.
module bcd60_inc (
  input  logic [7:0] value,
  input  logic [7:0] limit,
  output logic [7:0] next_value,
  output logic       carry
);
  always_comb begin
    carry      = value == limit;
    next_value = carry ? 8'h00 :
                 value[3:0] == 4'h9 ? {value[7:4] + 4'h1, 4'h0} : value + 8'h01;
  end
endmodule

// File: rtl/timekeeper.sv
// timekeeper: BCD hh:mm:ss clock with mode/adjust keys for setting hours and minutes.
module timekeeper
  import timekeeper_pkg::*;
#(
  parameter logic [7:0] HOUR_MAX = BCD_23
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       EN_1HZ,
  input  logic       MODE_KEY,
  input  logic       ADJ_KEY,
  output logic [7:0] TIME_H,
  output logic [7:0] TIME_M,
  output logic [7:0] TIME_S,
  output logic [1:0] SET_STATE,
  output logic       HOUR_PULSE
);
  logic [7:0] h_q, h_d, m_q, m_d, s_q, s_d;
  logic [1:0] state_q, state_d;
  logic       pulse_q, pulse_d, mode_prev_q, adj_prev_q;
  logic [7:0] h_next, m_next, s_next;
  logic       h_carry, m_carry, s_carry;
  logic       mode_p, adj_p, run;

  bcd60_inc u_sec  (.value(s_q), .limit(BCD_59),   .next_value(s_next), .carry(s_carry));
  bcd60_inc u_min  (.value(m_q), .limit(BCD_59),   .next_value(m_next), .carry(m_carry));
  bcd60_inc u_hour (.value(h_q), .limit(HOUR_MAX), .next_value(h_next), .carry(h_carry));

  // Encoding 11 falls through to RUN behaviour.
  always_comb begin
    mode_p  = MODE_KEY & ~mode_prev_q;
    adj_p   = ADJ_KEY & ~adj_prev_q;
    run     = state_q != SET_H && state_q != SET_M;
    h_d     = h_q;
    m_d     = m_q;
    s_d     = s_q;
    state_d = state_q;
    pulse_d = 1'b0;
    if (run && EN_1HZ) begin
      s_d = s_next;
      if (s_carry) m_d = m_next;
      if (s_carry && m_carry) begin
        h_d     = h_next;
        pulse_d = 1'b1;
      end
    end
    if (mode_p) begin
      state_d = run ? SET_H : state_q == SET_H ? SET_M : RUN;
      if (state_q == SET_M) s_d = 8'h00;
    end else if (adj_p) begin
      if (state_q == SET_H) h_d = h_next;
      if (state_q == SET_M) m_d = m_next;
    end
  end

  always_ff @(posedge CP) begin
    if (!nCR) begin
      h_q         <= 8'h00;
      m_q         <= 8'h00;
      s_q         <= 8'h00;
      state_q     <= RUN;
      pulse_q     <= 1'b0;
      mode_prev_q <= 1'b0;
      adj_prev_q  <= 1'b0;
    end else begin
      h_q         <= h_d;
      m_q         <= m_d;
      s_q         <= s_d;
      state_q     <= state_d;
      pulse_q     <= pulse_d;
      mode_prev_q <= MODE_KEY;
      adj_prev_q  <= ADJ_KEY;
    end
  end

  assign TIME_H     = h_q;
  assign TIME_M     = m_q;
  assign TIME_S     = s_q;
  assign SET_STATE  = state_q;
  assign HOUR_PULSE = pulse_q;
endmodule
